// File: rtl/data_memory_pipelined.sv
// Pipelined RV32/RV64 data memory: one load/store per cycle over valid/ready,
// fixed-latency in-order responses, access error reporting, post-reset clear.
module data_memory_pipelined #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_SIZE      = 64,
    parameter int READ_LATENCY  = 1,
    parameter int INIT_CLEAR    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(MEM_SIZE);

    typedef enum logic {
        S_INIT,
        S_READY
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [IDX_W-1:0]         r_cnt;
    logic                     r_ready;
    logic                     w_init_we;

    logic [DATA_WIDTH-1:0]    r_mem [MEM_SIZE];

    logic                     r_pv [READ_LATENCY];
    logic                     r_pe [READ_LATENCY];
    logic [DATA_WIDTH-1:0]    r_pd [READ_LATENCY];

    logic                     w_accept;
    logic [ADDRESS_WIDTH-1:0] w_index;
    logic [OFF_W-1:0]         w_off;
    logic [OFF_W+2:0]         w_shamt;
    logic                     w_in_range;
    logic [IDX_W-1:0]         w_mem_idx;
    logic [DATA_WIDTH-1:0]    w_word;
    logic [DATA_WIDTH-1:0]    w_shifted;
    logic [DATA_WIDTH-1:0]    w_lane_mask;
    logic [DATA_WIDTH-1:0]    w_store_mask;
    logic [OFF_W-1:0]         w_align_mask;
    logic                     w_sign_bit;
    logic                     w_legal;
    logic                     w_err;
    logic [DATA_WIDTH-1:0]    w_load;
    logic [DATA_WIDTH-1:0]    w_store_word;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_init_we    = 1'b0;
        case (r_state)
            S_INIT: begin
                w_init_we = 1'b1;
                if (r_cnt == IDX_W'(MEM_SIZE - 1)) begin
                    w_state_next = S_READY;
                end
            end
            default: w_state_next = S_READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= (INIT_CLEAR != 0) ? S_INIT : S_READY;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_init_we ? r_cnt + IDX_W'(1) : r_cnt;
            r_ready <= (w_state_next == S_READY);
        end
    end

    assign req_ready  = r_ready;
    assign w_accept   = req_valid & r_ready;

    // Word index never wraps: anything past the last word is an error.
    assign w_index    = req_addr >> OFF_W;
    assign w_off      = req_addr[OFF_W-1:0];
    assign w_shamt    = {w_off, 3'b000};
    assign w_in_range = w_index < ADDRESS_WIDTH'(MEM_SIZE);
    assign w_mem_idx  = w_in_range ? w_index[IDX_W-1:0] : '0;
    assign w_word     = r_mem[w_mem_idx];
    assign w_shifted  = w_word >> w_shamt;

    always_comb begin
        w_lane_mask  = '0;
        w_align_mask = '0;
        w_sign_bit   = 1'b0;
        case (req_funct3[1:0])
            2'b00: begin
                w_lane_mask  = DATA_WIDTH'(8'hFF);
                w_sign_bit   = w_shifted[7];
            end
            2'b01: begin
                w_lane_mask  = DATA_WIDTH'(16'hFFFF);
                w_align_mask = OFF_W'(1);
                w_sign_bit   = w_shifted[15];
            end
            2'b10: begin
                w_lane_mask  = DATA_WIDTH'(32'hFFFF_FFFF);
                w_align_mask = OFF_W'(3);
                w_sign_bit   = w_shifted[31];
            end
            default: begin
                w_lane_mask  = '1;
                w_align_mask = OFF_W'(7);
                w_sign_bit   = w_shifted[DATA_WIDTH-1];
            end
        endcase

        w_legal = 1'b0;
        if (req_write) begin
            w_legal = !req_funct3[2] && ((req_funct3[1:0] != 2'b11) || (DATA_WIDTH == 64));
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                3'b011, 3'b110:                         w_legal = (DATA_WIDTH == 64);
                default:                                w_legal = 1'b0;
            endcase
        end
    end

    assign w_err        = !w_legal || (|(w_off & w_align_mask)) || !w_in_range;
    // Signed forms (funct3[2]=0) fill everything above the lane with its MSB.
    assign w_load       = (w_shifted & w_lane_mask) |
                          ((!req_funct3[2] && w_sign_bit) ? ~w_lane_mask : '0);
    assign w_store_mask = w_lane_mask << w_shamt;
    assign w_store_word = (w_word & ~w_store_mask) | ((req_wdata << w_shamt) & w_store_mask);

    // NOTE: the array itself has no reset; the INIT sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_init_we) begin
                r_mem[r_cnt] <= '0;
            end else if (w_accept && req_write && !w_err) begin
                r_mem[w_mem_idx] <= w_store_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_pe[i] <= 1'b0;
                r_pd[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_accept;
            r_pe[0] <= w_accept && w_err;
            r_pd[0] <= (w_accept && !w_err && !req_write) ? w_load : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pe[i] <= r_pe[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    assign rsp_valid = r_pv[READ_LATENCY-1];
    assign rsp_err   = r_pe[READ_LATENCY-1];
    assign rsp_rdata = r_pd[READ_LATENCY-1];

endmodule
